eca_engine: RTL and testbench

- Parametrised successor to the fixed rule-110 512-cell automaton.
- Evolves a WIDTH-cell one-dimensional elementary cellular automaton under any of the 256 Wolfram rule numbers.
- Supports zero or wrap-around boundaries and runs a programmed number of generations per start command.
- Reports completion and early halt on a fixed point. Used as a pattern/stimulus generator and as a compute kernel in the automaton family.

---
 rtl/eca_pkg.sv | 14 +
 rtl/eca_step.sv | 27 ++
 rtl/eca_engine.sv | 124 ++++++++++++
 tb/tb_eca_engine.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/eca_pkg.sv
// Shared types and constants for the elementary cellular automaton engine.
package eca_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Rule number of the fixed-function predecessor; the engine defaults to
  // nothing in particular, but callers use this to reproduce the old block.
  localparam logic [7:0] RULE_110 = 8'd110;

endpackage

// File: rtl/eca_step.sv
// One generation of an elementary cellular automaton, purely combinational.
// Cell i looks at {q[i+1], q[i], q[i-1]} and takes that bit of the rule.
module eca_step
  import eca_pkg::*;
#(
  parameter int WIDTH = 512
) (
  input  logic [WIDTH-1:0] q,
  input  logic [7:0]       rule,
  input  logic             wrap,
  output logic [WIDTH-1:0] nxt
);

  // Extended vector: ext[i+1] = q[i]; ext[0] and ext[WIDTH+1] are the
  // boundary neighbours, either zero or the opposite edge cell.
  logic [WIDTH+1:0] ext;

  // Build the padded neighbourhood and look each cell up in the rule table.
  always_comb begin
    ext = {(wrap ? q[0] : 1'b0), q, (wrap ? q[WIDTH-1] : 1'b0)};
    nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      nxt[i] = rule[{ext[i+2], ext[i+1], ext[i]}];
    end
  end

endmodule

// File: rtl/eca_engine.sv
// Runs a programmed number of generations of an elementary cellular
// automaton, halting early when the pattern reaches a fixed point.
module eca_engine
  import eca_pkg::*;
#(
  parameter int WIDTH = 512,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [7:0]       rule,
  input  logic             wrap,
  input  logic             start,
  input  logic [GEN_W-1:0] gens,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             stable,
  output logic [GEN_W-1:0] gen_count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [7:0]       rule_q, rule_d;
  logic             wrap_q, wrap_d;
  logic [GEN_W-1:0] target_q, target_d;
  logic [GEN_W-1:0] gen_count_q, gen_count_d;
  logic             stable_q, stable_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] nxt;
  logic [GEN_W-1:0] gen_inc;

  eca_step #(.WIDTH(WIDTH)) u_step (
    .q    (q_q),
    .rule (rule_q),
    .wrap (wrap_q),
    .nxt  (nxt)
  );

  // Next-state logic: load pre-empts everything, then the IDLE/RUN/DONE flow.
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    rule_d      = rule_q;
    wrap_d      = wrap_q;
    target_d    = target_q;
    gen_count_d = gen_count_q;
    stable_d    = stable_q;
    gen_inc     = gen_count_q + GEN_W'(1);

    if (load) begin
      q_d         = data;
      state_d     = S_IDLE;
      gen_count_d = '0;
      stable_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            rule_d      = rule;
            wrap_d      = wrap;
            target_d    = gens;
            gen_count_d = '0;
            stable_d    = 1'b0;
            state_d     = (gens == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          q_d         = nxt;
          gen_count_d = gen_inc;
          // A fixed point wins over the count so stable is reported even
          // when both happen on the same generation.
          if (nxt == q_q) begin
            stable_d = 1'b1;
            state_d  = S_DONE;
          end else if (gen_inc == target_q) begin
            state_d  = S_DONE;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset clears the whole engine.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      q_q         <= '0;
      rule_q      <= '0;
      wrap_q      <= 1'b0;
      target_q    <= '0;
      gen_count_q <= '0;
      stable_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      rule_q      <= rule_d;
      wrap_q      <= wrap_d;
      target_q    <= target_d;
      gen_count_q <= gen_count_d;
      stable_q    <= stable_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign q         = q_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign stable    = stable_q;
  assign gen_count = gen_count_q;

endmodule

// File: tb/tb_eca_engine.sv
// Bench for eca_engine: a cycle model of the run protocol checked every
// cycle on a 512-cell instance, plus literal checks on 512- and 8-cell builds.
module tb_eca_engine;
  import eca_pkg::*;

  localparam int W  = 512;
  localparam int GW = 16;

  logic          clk;
  logic          reset;
  logic          load, wrap, start;
  logic [W-1:0]  data;
  logic [7:0]    rule;
  logic [GW-1:0] gens;
  logic [W-1:0]  q;
  logic          busy, done, stable;
  logic [GW-1:0] gen_count;

  logic          load8, wrap8, start8;
  logic [7:0]    data8, rule8;
  logic [GW-1:0] gens8;
  logic [7:0]    q8;
  logic          busy8, done8, stable8;
  logic [GW-1:0] gc8;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  eca_engine #(.WIDTH(W), .GEN_W(GW)) dut (
    .clk(clk), .reset(reset), .load(load), .data(data), .rule(rule),
    .wrap(wrap), .start(start), .gens(gens), .q(q), .busy(busy),
    .done(done), .stable(stable), .gen_count(gen_count)
  );

  eca_engine #(.WIDTH(8), .GEN_W(GW)) dut8 (
    .clk(clk), .reset(reset), .load(load8), .data(data8), .rule(rule8),
    .wrap(wrap8), .start(start8), .gens(gens8), .q(q8), .busy(busy8),
    .done(done8), .stable(stable8), .gen_count(gc8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference generation: each cell's neighbourhood read as a number 0..7
  // selects one bit of the rule number by shifting.
  function automatic logic [W-1:0] model_next(input logic [W-1:0] s,
                                              input logic [7:0] r,
                                              input logic w);
    logic [W-1:0] n;
    int l, c, rr, k;
    for (int i = 0; i < W; i++) begin
      l  = (i == W-1) ? (w ? int'(s[0]) : 0) : int'(s[i+1]);
      c  = int'(s[i]);
      rr = (i == 0) ? (w ? int'(s[W-1]) : 0) : int'(s[i-1]);
      k  = l * 4 + c * 2 + rr;
      n[i] = ((int'(r) >> k) & 1) == 1;
    end
    return n;
  endfunction

  // Behavioural model of what the engine must show after each edge.
  logic [W-1:0]  m_q, m_nq;
  logic [7:0]    m_rule;
  logic          m_wrap, m_running, m_done, m_stable;
  logic [GW-1:0] m_tgt, m_gc;

  always @(posedge clk) begin
    if (reset) begin
      m_q = '0; m_rule = '0; m_wrap = 0; m_tgt = '0; m_gc = '0;
      m_running = 0; m_done = 0; m_stable = 0;
    end else if (load) begin
      m_q = data; m_gc = '0; m_stable = 0; m_running = 0; m_done = 0;
    end else if (m_running) begin
      m_nq = model_next(m_q, m_rule, m_wrap);
      m_gc = m_gc + 1'b1;
      if (m_nq == m_q) m_stable = 1;
      if (m_nq == m_q || m_gc == m_tgt) begin
        m_running = 0; m_done = 1;
      end
      m_q = m_nq;
    end else if (m_done) begin
      m_done = 0;
    end else if (start) begin
      m_rule = rule; m_wrap = wrap; m_tgt = gens; m_gc = '0; m_stable = 0;
      if (gens == '0) m_done = 1;
      else            m_running = 1;
    end
  end

  // Every-cycle comparison of the 512-cell DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (q !== m_q || busy !== m_running || done !== m_done ||
          stable !== m_stable || gen_count !== m_gc) begin
        n_fail++;
        $display("FAIL cycle t=%0t: busy/done/stable/gc got %b%b%b/%0d want %b%b%b/%0d q got %h want %h",
                 $time, busy, done, stable, gen_count, m_running, m_done, m_stable, m_gc, q, m_q);
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_load(input logic [W-1:0] d);
    load = 1; data = d; cyc(); load = 0;
  endtask

  task automatic do_start(input logic [7:0] r, input logic w, input logic [GW-1:0] g);
    rule = r; wrap = w; gens = g; start = 1; cyc(); start = 0;
  endtask

  task automatic wait_done(input int limit, input string nm);
    bit got = 0;
    for (int k = 0; k < limit && !got; k++) begin
      cyc();
      if (done) got = 1;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s: no done within %0d cycles", nm, limit);
    end
  endtask

  task automatic run8(input logic w, output logic [7:0] res);
    load8 = 1; data8 = 8'h01; cyc(); load8 = 0;
    rule8 = 8'd90; wrap8 = w; gens8 = 16'd1; start8 = 1; cyc(); start8 = 0;
    cyc();
    res = q8;
    cyc();
  endtask

  logic [W-1:0] rd;
  logic [7:0]   r8;

  initial begin
    reset = 1; load = 0; wrap = 0; start = 0; data = '0; rule = '0; gens = '0;
    load8 = 0; wrap8 = 0; start8 = 0; data8 = '0; rule8 = '0; gens8 = '0;
    cyc(); chk_en = 1; cyc();
    reset = 0;
    chk("reset_q", q, '0);
    chk("reset_flags", {busy, done, stable}, 3'b000);
    chk("reset_gc", gen_count, '0);

    // Rule 110, zero boundary, from a single live cell.
    do_load(1);
    do_start(RULE_110, 0, 16'd3);
    chk("r110_busy", busy, 1);
    cyc(); chk("r110_g1", q, 512'h3);
    cyc(); chk("r110_g2", q, 512'h7);
    cyc(); chk("r110_g3", q, 512'hD);
    chk("r110_done", {done, busy, stable}, 3'b100);
    chk("r110_gc", gen_count, 3);
    cyc(); chk("r110_done_gone", done, 0);

    // Rule 90 on 8 cells, toroidal and zero boundaries.
    run8(1, r8); chk("r90_wrap", r8, 8'h82);
    run8(0, r8); chk("r90_zero", r8, 8'h02);

    // Identity rule halts after one generation as a fixed point.
    do_load(512'h4DF);
    do_start(8'd204, 0, 16'd100);
    cyc();
    chk("id_q", q, 512'h4DF);
    chk("id_flags", {done, stable, busy}, 3'b110);
    chk("id_gc", gen_count, 1);
    cyc(); chk("id_one_pulse", done, 0);
    chk("id_sticky", stable, 1);

    // Load aborts a long run without a done pulse.
    do_load(1);
    do_start(RULE_110, 0, 16'd1000);
    repeat (5) cyc();
    do_load(512'h9);
    chk("abort_q", q, 512'h9);
    chk("abort_flags", {busy, done, stable}, 3'b000);
    chk("abort_gc", gen_count, 0);
    repeat (3) cyc();
    chk("abort_no_done", done, 0);

    // load and start together: only the load takes effect.
    load = 1; data = 512'h5; rule = RULE_110; gens = 16'd4; start = 1; cyc();
    load = 0; start = 0;
    chk("ls_q", q, 512'h5);
    cyc(); chk("ls_idle", busy, 0);

    // Zero generations completes immediately.
    do_start(RULE_110, 0, 16'd0);
    chk("g0_done", {done, busy}, 2'b10);
    chk("g0_q", q, 512'h5);
    chk("g0_gc", gen_count, 0);
    cyc();

    // A second start while busy must not relatch gens.
    do_start(RULE_110, 0, 16'd4);
    do_start(8'd204, 1, 16'd1);
    wait_done(20, "busy_start_done");
    chk("busy_start_gc", gen_count, 4);
    cyc();

    // Reset in the middle of a run.
    do_start(RULE_110, 0, 16'd50);
    repeat (3) cyc();
    reset = 1; cyc(); reset = 0;
    chk("rst_q", q, '0);
    chk("rst_flags", {busy, done, stable}, 3'b000);
    chk("rst_gc", gen_count, 0);

    // Long random runs under both boundary modes.
    for (int k = 0; k < 16; k++) rd[k*32 +: 32] = $urandom;
    do_load(rd);
    do_start(RULE_110, 0, 16'd1000);
    wait_done(1100, "rand_r110_done");
    chk("rand_r110_gc", gen_count, 1000);
    cyc();
    for (int k = 0; k < 16; k++) rd[k*32 +: 32] = $urandom;
    do_load(rd);
    do_start(8'd30, 1, 16'd1000);
    wait_done(1100, "rand_r30_done");
    chk("rand_r30_gc", gen_count, 1000);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
